// File: rtl/store_narrower.sv
// Sub-word store narrowing for a word-only data memory: SW writes directly; SB/SH read-modify-write.
// Latency: accept cycle through the done pulse is 3 cycles (SW) or 4 (SB/SH) with zero-wait memory; req_ready only in IDLE.
module store_narrower (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        reject;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    assign reject = (req_size == SZ_ILL)
                  | ((req_size == SZ_HALF) & req_addr[0])
                  | ((req_size == SZ_WORD) & (|req_addr[1:0]));

    // Only the addressed lane(s) change; the rest of the word is preserved from memory.
    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_BYTE) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data[15:0];
                    size_d = req_size;
                    if (reject) begin
                        state_d = FAULT;
                    end else if (req_size == SZ_WORD) begin
                        wdata_d = req_data;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (mem_rvalid) begin
                    wdata_d = merged;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign req_ready = (state_q == IDLE);
    assign mem_rd_en = (state_q == READ);
    assign mem_wr_en = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign fault     = (state_q == FAULT);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Store-side counterpart of the immediate/load extender: takes a 32-bit register value and a store size (SB/SH/SW).
- Truncates the value to the byte or halfword and places it in its little-endian byte lane.
- Writes it to a word-only data memory (no byte enables). Sub-word stores use a read-modify-write sequence.
- Sits between the MEM-stage store path and the data memory port.

Parameters:
- none; datapath fixed at 32 bits, byte-addressed, little-endian (lane 0 = bits 7:0).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request
- req_addr  input  32  byte address
- req_data  input  32  register value to store
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_addr  output  32  word address to memory; bits [1:0] always 00
- mem_rd_en  output  1  read request, held until mem_rvalid
- mem_rdata  input  32  read data
- mem_rvalid  input  1  read data valid
- mem_wr_en  output  1  write request, held until mem_ack
- mem_wdata  output  32  merged write word
- mem_ack  input  1  write accepted
- done  output  1  one-cycle pulse: store completed
- fault  output  1  one-cycle pulse: request rejected (misaligned or illegal size)

Behaviour:
- Reset values:
  - State IDLE.
  - mem_addr, mem_wdata, mem_rd_en, mem_wr_en, done, fault all 0.
  - Internal captured request cleared.
- req_ready = (state == IDLE). It is combinational, so it reads 1 while reset is asserted.
- Handshake: a request is accepted on the edge where req_valid & req_ready. addr, data and size are captured then; inputs are don't-care afterwards.
- Rejection checks on accept:
  - size 11 → reject.
  - halfword with addr[0]=1 → reject.
  - word with addr[1:0]≠00 → reject.
- States and transitions:
  - IDLE:
    - accept + reject → FAULT.
    - accept + word → WRITE, with mem_wdata = req_data.
    - accept + byte or half → READ.
  - FAULT: fault=1 for one cycle; no memory access → IDLE.
  - READ: mem_rd_en=1, mem_addr = {addr[31:2],2'b00}.
    - On mem_rvalid, merge mem_rdata → WRITE. mem_rd_en deasserts on the same edge.
    - Merge rules:
      - byte: lane addr[1:0] replaced with data[7:0].
      - half: bits [15:0] if addr[1]=0, else [31:16], replaced with data[15:0].
      - All other bits come from mem_rdata.
  - WRITE: mem_wr_en=1, mem_addr as above, mem_wdata stable.
    - On mem_ack → DONE; mem_wr_en deasserts on that edge.
  - DONE: done=1 for one cycle → IDLE.
- Latency with zero-wait memory, counted from the accept edge to the done pulse:
  - Word store: 3 cycles.
  - Sub-word store: 4 cycles.
- mem_rvalid outside READ and mem_ack outside WRITE are ignored.
- Memory may respond in the first cycle of a request.
- No back-to-back accept while not IDLE. A new request is accepted the cycle after done or fault (IDLE).
- Truncation discards the upper bits of req_data with no sign check. This mirrors the load extender, which reconstructs those bits.
- Reset mid-operation:
  - Returns to IDLE immediately (asynchronously).
  - Drops mem_rd_en and mem_wr_en, aborting the transaction.
  - No done or fault is generated.

Test Plan:
- SW: addr=0x100, data=0xDEADBEEF, zero-wait memory → mem_wr_en with mem_addr=0x100, mem_wdata=0xDEADBEEF; no mem_rd_en; done exactly 3 cycles after accept.
- SB, all four lanes: memory word 0x11223344, data=0xFFFFFFAB:
  - addr 0x201 → mem_wdata=0x1122AB44.
  - addr 0x203 → 0xAB223344.
  - addr 0x200 → 0x112233AB.
  - addr 0x202 → 0x11AB3344.
  - mem_addr=0x200 for all.
- SH: memory 0xCAFEF00D, data=0x12345678:
  - addr 0x302 → 0x5678F00D.
  - addr 0x300 → 0xCAFE5678.
- Faults:
  - SH at 0x301 → fault pulse.
  - SW at 0x102 → fault pulse.
  - size=11 → fault pulse.
  - In all three cases: no mem_rd_en or mem_wr_en, no done; req_ready back to 1 two cycles after accept.
- Wait states: mem_rvalid delayed 3 cycles, mem_ack delayed 2 cycles → enables held stable until response, mem_wdata unchanged, single done pulse; spurious mem_ack during READ ignored.
- Reset mid-READ: deassert reset_n while mem_rd_en=1 → mem_rd_en=0 immediately, no done, req_ready=1; a following SW completes normally.
